// File: rtl/mult_pkg.sv
// Shared state encoding and timing helper for the memory-mapped multiplier engine.
package mult_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;

  // Cycles spent on one operand pair: load 2B+1, multiply 8B, store 2B.
  function automatic int lat_per_pair(input int b);
    return 12 * b + 1;
  endfunction

endpackage

// File: rtl/booth_mul_core.sv
// Iterative N-cycle multiplier: radix-2 Booth recoding when SIGNED, plain shift-add otherwise.
module booth_mul_core #(
  parameter int N      = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] product,
  output logic           valid
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  mcand_reg;
  logic [N:0]    hi_reg;
  logic [N-1:0]  lo_reg;
  logic          qm1_reg;
  logic [CW-1:0] cnt_reg;
  logic          valid_reg;

  logic [N-1:0]  m_cur;
  logic [N:0]    m_ext;
  logic [N:0]    hi_cur;
  logic [N-1:0]  lo_cur;
  logic          qm1_cur;
  logic [N:0]    sum;

  // The load cycle already performs the first step, so the product is final
  // after exactly N edges and valid is seen during the N-th cycle.
  always_comb begin
    m_cur   = load ? mcand : mcand_reg;
    m_ext   = SIGNED ? {m_cur[N-1], m_cur} : {1'b0, m_cur};
    hi_cur  = load ? '0 : hi_reg;
    lo_cur  = load ? mplier : lo_reg;
    qm1_cur = load ? 1'b0 : qm1_reg;
    sum     = hi_cur;
    if (SIGNED) begin
      case ({lo_cur[0], qm1_cur})
        2'b01:   sum = hi_cur + m_ext;
        2'b10:   sum = hi_cur - m_ext;
        default: sum = hi_cur;
      endcase
    end else if (lo_cur[0]) begin
      sum = hi_cur + m_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      qm1_reg   <= 1'b0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (load || cnt_reg != '0) begin
        hi_reg  <= {(SIGNED ? sum[N] : 1'b0), sum[N:1]};
        lo_reg  <= {sum[0], lo_cur[N-1:1]};
        qm1_reg <= lo_cur[0];
      end
      if (load) begin
        mcand_reg <= mcand;
        cnt_reg   <= CW'(N - 1);
        valid_reg <= (N == 1);
      end else if (cnt_reg != '0) begin
        cnt_reg   <= cnt_reg - CW'(1);
        valid_reg <= (cnt_reg == CW'(1));
      end
    end
  end

  assign product = {hi_reg[N-1:0], lo_reg};
  assign valid   = valid_reg;

endmodule

// File: rtl/mem_mult_engine.sv
// Memory-mapped multiplier: streams operand pairs from byte memory, multiplies,
// and writes full-width products back big-endian.
module mem_mult_engine #(
  parameter int OP_BYTES  = 2,
  parameter int NUM_PAIRS = 16,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 64,
  parameter int ADDR_W    = 8,
  parameter bit SIGNED    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done
);
  import mult_pkg::*;

  localparam int N  = 8 * OP_BYTES;
  localparam int NB = 2 * OP_BYTES;
  localparam int CW = $clog2(NB + 1);
  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  state_t            state_reg;
  logic [PW-1:0]     pair_idx_reg;
  logic [CW-1:0]     byte_cnt_reg;
  logic [2*N-1:0]    opnd_reg;
  logic [2*N-1:0]    opnd_next;
  logic [2*N-1:0]    prod_reg;
  logic [ADDR_W-1:0] src_ptr_reg;
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic              start_reg;
  logic              rd_pend_reg;
  logic              core_load;
  logic              core_valid;
  logic [2*N-1:0]    core_product;

  // Read data arrives one cycle after the request; the final byte is folded in
  // combinationally so the multiplier can start on the same edge it lands.
  assign opnd_next = rd_pend_reg ? {opnd_reg[2*N-9:0], mem_rdata} : opnd_reg;
  assign core_load = (state_reg == LOAD) && (byte_cnt_reg == CW'(NB));

  booth_mul_core #(.N(N), .SIGNED(SIGNED)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .mcand   (opnd_next[2*N-1:N]),
    .mplier  (opnd_next[N-1:0]),
    .product (core_product),
    .valid   (core_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pair_idx_reg <= '0;
      byte_cnt_reg <= '0;
      opnd_reg     <= '0;
      prod_reg     <= '0;
      src_ptr_reg  <= '0;
      dst_ptr_reg  <= '0;
      start_reg    <= 1'b0;
      rd_pend_reg  <= 1'b0;
      mem_addr     <= '0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Start only counts when sampled while idle or finished.
      start_reg   <= start && (state_reg == IDLE || state_reg == DONE);
      rd_pend_reg <= mem_rd_en;
      opnd_reg    <= opnd_next;
      case (state_reg)
        IDLE, DONE: begin
          if (start_reg) begin
            state_reg    <= LOAD;
            pair_idx_reg <= '0;
            byte_cnt_reg <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            mem_rd_en    <= 1'b1;
            mem_addr     <= ADDR_W'(SRC_BASE);
            src_ptr_reg  <= ADDR_W'(SRC_BASE + NB);
            dst_ptr_reg  <= ADDR_W'(DST_BASE);
          end
        end
        LOAD: begin
          byte_cnt_reg <= byte_cnt_reg + CW'(1);
          if (byte_cnt_reg < CW'(NB - 1)) mem_addr <= mem_addr + ADDR_W'(1);
          else mem_rd_en <= 1'b0;
          if (byte_cnt_reg == CW'(NB)) begin
            state_reg    <= MUL;
            byte_cnt_reg <= '0;
          end
        end
        MUL: begin
          if (core_valid) begin
            state_reg    <= STORE;
            byte_cnt_reg <= '0;
            mem_wr_en    <= 1'b1;
            mem_addr     <= dst_ptr_reg;
            mem_wdata    <= core_product[2*N-1 -: 8];
            prod_reg     <= core_product << 8;
          end
        end
        STORE: begin
          if (byte_cnt_reg == CW'(NB - 1)) begin
            mem_wr_en    <= 1'b0;
            byte_cnt_reg <= '0;
            dst_ptr_reg  <= dst_ptr_reg + ADDR_W'(NB);
            if (pair_idx_reg == PW'(NUM_PAIRS - 1)) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg    <= LOAD;
              pair_idx_reg <= pair_idx_reg + PW'(1);
              mem_rd_en    <= 1'b1;
              mem_addr     <= src_ptr_reg;
              src_ptr_reg  <= src_ptr_reg + ADDR_W'(NB);
            end
          end else begin
            byte_cnt_reg <= byte_cnt_reg + CW'(1);
            mem_addr     <= mem_addr + ADDR_W'(1);
            mem_wdata    <= prod_reg[2*N-1 -: 8];
            prod_reg     <= prod_reg << 8;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_mult_engine.sv
// Randomised bench for mem_mult_engine: byte memory models, arithmetic reference, run timing.
module tb_mem_mult_engine;
  import mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [7:0] rdata0 = 8'h00, rdata1 = 8'h00;
  logic       rd0, rd1, wr0, wr1, busy0, busy1, done0, done1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       pl_en = 1'b0, pl_sel = 1'b0;
  logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

  int     tests = 0, fails = 0, excl_err = 0;
  longint opa [2][16];
  longint opb [2][16];

  mem_mult_engine dut0 (
    .clk(clk), .reset(reset), .start(start0), .mem_addr(addr0), .mem_rd_en(rd0),
    .mem_rdata(rdata0), .mem_wr_en(wr0), .mem_wdata(wdata0), .busy(busy0), .done(done0)
  );

  mem_mult_engine #(.OP_BYTES(3), .NUM_PAIRS(2), .SIGNED(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mem_addr(addr1), .mem_rd_en(rd1),
    .mem_rdata(rdata1), .mem_wr_en(wr1), .mem_wdata(wdata1), .busy(busy1), .done(done1)
  );

  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem0[pl_addr] <= pl_data;
    else if (wr0) mem0[addr0] <= wdata0;
    if (rd0) rdata0 <= mem0[addr0];
    if (pl_en && pl_sel) mem1[pl_addr] <= pl_data;
    else if (wr1) mem1[addr1] <= wdata1;
    if (rd1) rdata1 <= mem1[addr1];
  end

  // Strobes must be exclusive and only active while busy.
  always @(negedge clk) begin
    if ((rd0 && wr0) || (!busy0 && (rd0 || wr0)) || (rd1 && wr1) || (!busy1 && (rd1 || wr1)))
      excl_err <= excl_err + 1;
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] byte_of(input longint v, input int k);
    return 8'((v >> (8 * k)) & 255);
  endfunction

  function automatic logic [7:0] rd_mem(input int sel, input int a);
    logic [7:0] ai;
    ai = a[7:0];
    return (sel != 0) ? mem1[ai] : mem0[ai];
  endfunction

  function automatic longint rnd_op(input int sel);
    if (sel != 0) return longint'($urandom_range(0, 24'hFFFFFF));
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill(input int sel);
    for (int j = 0; j < 16; j++) begin
      opa[sel][j] = rnd_op(sel);
      opb[sel][j] = rnd_op(sel);
    end
  endtask

  task automatic put_byte(input int sel, input int a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = (sel != 0); pl_addr = a[7:0]; pl_data = d;
  endtask

  // Operands big-endian from address 0, product area filled with 0xAA.
  task automatic preload(input int sel);
    int b, np;
    b = (sel != 0) ? 3 : 2;
    np = (sel != 0) ? 2 : 16;
    for (int j = 0; j < np; j++)
      for (int k = 0; k < b; k++) begin
        put_byte(sel, 2*j*b + k, byte_of(opa[sel][j], b-1-k));
        put_byte(sel, 2*j*b + b + k, byte_of(opb[sel][j], b-1-k));
      end
    for (int k = 0; k < 2*np*b; k++) put_byte(sel, 64 + k, 8'hAA);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_run(input int sel, input int run, input int repulse_at);
    int b, np, n;
    logic bz_first, dn_first, d, bz;
    b = (sel != 0) ? 3 : 2;
    np = (sel != 0) ? 2 : 16;
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    if (sel != 0) start1 = 1'b0; else start0 = 1'b0;
    n = 0; bz_first = 1'b0; dn_first = 1'b1; d = 1'b0; bz = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (sel != 0) start1 = (n == repulse_at); else start0 = (n == repulse_at);
      d = (sel != 0) ? done1 : done0;
      bz = (sel != 0) ? busy1 : busy0;
      if (n == 1) begin bz_first = bz; dn_first = d; end
    end while (!d && n < 2000);
    start0 = 1'b0; start1 = 1'b0;
    check($sformatf("run%0d_busy_rise", run), longint'(bz_first), 1);
    check($sformatf("run%0d_done_clear", run), longint'(dn_first), 0);
    check($sformatf("run%0d_latency", run), longint'(n), longint'(1 + np * lat_per_pair(b)));
    check($sformatf("run%0d_busy_fall", run), longint'(bz), 0);
    $display("[TB] run %0d dut%0d: done %0d cycles after start sample", run, sel, n);
  endtask

  // Products for pairs below 'upto' must match; the rest must still be 0xAA fill.
  task automatic check_products(input int sel, input int run, input int upto);
    int b, np;
    b = (sel != 0) ? 3 : 2;
    np = (sel != 0) ? 2 : 16;
    for (int j = 0; j < np; j++) begin
      longint obs, expv;
      obs = 0; expv = 0;
      for (int k = 0; k < 2*b; k++) begin
        obs = (obs << 8) | longint'(rd_mem(sel, 64 + 2*j*b + k));
        expv = (expv << 8) | 64'hAA;
      end
      if (j < upto) expv = (opa[sel][j] * opb[sel][j]) & ((longint'(1) << (16 * b)) - 1);
      check($sformatf("run%0d_dut%0d_prod%0d", run, sel, j), obs, expv);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", longint'(busy0), 0);
    check("rst_done0", longint'(done0), 0);
    check("rst_rd0", longint'(rd0), 0);
    check("rst_wr0", longint'(wr0), 0);
    check("rst_addr0", longint'(addr0), 0);
    check("rst_wdata0", longint'(wdata0), 0);
    check("rst_busy1", longint'(busy1), 0);
    check("rst_done1", longint'(done1), 0);
    @(negedge clk);
    reset = 1'b0;

    // Small known pair first, rest random.
    fill(0);
    opa[0][0] = 3; opb[0][0] = 5;
    preload(0);
    do_run(0, 1, 0);
    check_products(0, 1, 16);

    // Corner operands; launched from DONE with a start re-pulse mid-run.
    fill(0);
    opa[0][0] = -1;     opb[0][0] = -1;
    opa[0][1] = -32768; opb[0][1] = -32768;
    opa[0][2] = -32768; opb[0][2] = 32767;
    opa[0][15] = 0;     opb[0][15] = -7;
    preload(0);
    do_run(0, 2, 100);
    check_products(0, 2, 16);

    // Abort with reset 60 cycles into the run, then rerun from IDLE.
    fill(0);
    preload(0);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (60) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", longint'(busy0), 0);
    check("abort_done", longint'(done0), 0);
    check("abort_wr", longint'(wr0), 0);
    check("abort_rd", longint'(rd0), 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    check_products(0, 3, 2);
    do_run(0, 4, 0);
    check_products(0, 4, 16);

    // Unsigned 3-byte instance.
    fill(1);
    opa[1][0] = 64'hFFFFFF; opb[1][0] = 64'hFFFFFF;
    preload(1);
    do_run(1, 5, 0);
    check_products(1, 5, 2);

    for (int r = 6; r < 8; r++) begin
      fill(0);
      preload(0);
      do_run(0, r, 0);
      check_products(0, r, 16);
    end

    fill(1);
    preload(1);
    do_run(1, 8, 0);
    check_products(1, 8, 2);

    @(negedge clk);
    check("rdwr_strobe_rules", longint'(excl_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
